// File: rtl/zh6_seq_gen_if.sv
// Symbol-stream bus between the zh6 frame generator and whatever drives its handshake.
// The master side issues Start/Repeat/Corrupt; the slave side (the generator) returns the stream.
interface zh6_seq_gen_if;
   logic       Start;
   logic       Repeat;
   logic       Corrupt;
   logic [1:0] Dout;
   logic       Busy;
   logic       Done;
   logic [1:0] Sym_idx;

   modport master (
      output Start,
      output Repeat,
      output Corrupt,
      input  Dout,
      input  Busy,
      input  Done,
      input  Sym_idx
   );

   modport slave (
      input  Start,
      input  Repeat,
      input  Corrupt,
      output Dout,
      output Busy,
      output Done,
      output Sym_idx
   );
endinterface

// File: rtl/zh6_seq_gen.sv
// Frame transmitter for the zh6 2-bit sequence detector: emits SYM0,SYM1,SYM2 separated by
// idle 2'b00 gaps, with Start/Busy/Done handshake, back-to-back repeat and a corrupt mode.
module zh6_seq_gen #(
   parameter int unsigned HOLD = 1,
   parameter int unsigned GAP  = 1,
   parameter logic [1:0]  SYM0 = 2'b01,
   parameter logic [1:0]  SYM1 = 2'b11,
   parameter logic [1:0]  SYM2 = 2'b10
) (
   input logic          Clk,
   input logic          Reset,
   zh6_seq_gen_if.slave bus
);

   localparam logic [7:0] HoldInit   = 8'(HOLD - 1);
   localparam logic [7:0] GapInit    = (GAP == 0) ? 8'd0 : 8'(GAP - 1);
   localparam logic [1:0] CorruptSym = 2'b01;
   localparam logic [1:0] LastIdx    = 2'd2;

   typedef enum logic [1:0] {
      StIdle,
      StSend,
      StGap,
      StDone
   } state_e;

   state_e     state_q, state_d;
   logic [1:0] idx_q, idx_d;
   logic [7:0] hold_q, hold_d;
   logic [7:0] gap_q, gap_d;
   logic       corrupt_q, corrupt_d;

   logic [1:0] dout_q, dout_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic [1:0] sym_idx_q, sym_idx_d;

   logic [1:0] sym_cur;

   // Corrupt replaces only the last symbol, so the detector never sees a complete frame.
   always_comb begin
      sym_cur = 2'b00;
      unique case (idx_q)
         2'd0:    sym_cur = SYM0;
         2'd1:    sym_cur = SYM1;
         2'd2:    sym_cur = corrupt_q ? CorruptSym : SYM2;
         default: sym_cur = 2'b00;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      hold_d    = hold_q;
      gap_d     = gap_q;
      corrupt_d = corrupt_q;

      unique case (state_q)
         StIdle: begin
            if (bus.Start) begin
               state_d   = StSend;
               idx_d     = 2'd0;
               hold_d    = HoldInit;
               corrupt_d = bus.Corrupt;
            end
         end

         StSend: begin
            if (hold_q != 8'd0) begin
               hold_d = hold_q - 8'd1;
            end else if (GAP != 0) begin
               state_d = StGap;
               gap_d   = GapInit;
            end else if (idx_q == LastIdx) begin
               state_d = StDone;
            end else begin
               idx_d  = idx_q + 2'd1;
               hold_d = HoldInit;
            end
         end

         StGap: begin
            if (gap_q != 8'd0) begin
               gap_d = gap_q - 8'd1;
            end else if (idx_q == LastIdx) begin
               state_d = StDone;
            end else begin
               state_d = StSend;
               idx_d   = idx_q + 2'd1;
               hold_d  = HoldInit;
            end
         end

         StDone: begin
            if (bus.Repeat || bus.Start) begin
               state_d   = StSend;
               idx_d     = 2'd0;
               hold_d    = HoldInit;
               corrupt_d = bus.Corrupt;
            end else begin
               state_d = StIdle;
            end
         end

         default: state_d = StIdle;
      endcase
   end

   // Outputs are a registered decode of the current state, so each output lags the state
   // register by one edge and Dout never passes through an intermediate value.
   always_comb begin
      dout_d    = 2'b00;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      sym_idx_d = idx_q;

      unique case (state_q)
         StIdle: sym_idx_d = 2'd0;
         StSend: begin
            dout_d = sym_cur;
            busy_d = 1'b1;
         end
         StGap:   busy_d = 1'b1;
         StDone:  done_d = 1'b1;
         default: sym_idx_d = 2'd0;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q   <= StIdle;
         idx_q     <= 2'd0;
         hold_q    <= 8'd0;
         gap_q     <= 8'd0;
         corrupt_q <= 1'b0;
         dout_q    <= 2'b00;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         sym_idx_q <= 2'd0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         hold_q    <= hold_d;
         gap_q     <= gap_d;
         corrupt_q <= corrupt_d;
         dout_q    <= dout_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         sym_idx_q <= sym_idx_d;
      end
   end

   assign bus.Dout    = dout_q;
   assign bus.Busy    = busy_q;
   assign bus.Done    = done_q;
   assign bus.Sym_idx = sym_idx_q;

endmodule
